thirtytwo_bits_divider: RTL and testbench

Sequential 64-by-32 unsigned divider, the inverse of the 32×32 multiplier datapath. It takes a 64-bit dividend, typically a full multiplier product, and a 32-bit divisor, and returns a 32-bit quotient and a 32-bit remainder. It uses a restoring shift-subtract algorithm at one quotient bit per clock, behind a start/busy/done handshake. It sits beside the multiplier in the arithmetic unit, so a product can be divided back to recover its operands.

---
 rtl/thirtytwo_bits_divider_if.sv | 22 ++
 rtl/thirtytwo_bits_divider.sv | 110 +++++++++++
 tb/tb_thirtytwo_bits_divider.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/thirtytwo_bits_divider_if.sv
// Start/busy/done handshake and operand/result bundle for the 64-by-32 unsigned divider.
interface thirtytwo_bits_divider_if;
    logic        start;
    logic [63:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic        overflow;

    modport master (
        output start, a, b,
        input  q, r, busy, done, div_zero, overflow
    );

    modport slave (
        input  start, a, b,
        output q, r, busy, done, div_zero, overflow
    );
endinterface

// File: rtl/thirtytwo_bits_divider.sv
// Sequential 64/32 unsigned restoring divider, one quotient bit per clock.
// Divide-by-zero and quotient overflow are detected up front and exit via a one-cycle flag state.
module thirtytwo_bits_divider (
    input logic                       clk,
    input logic                       rst_n,
    thirtytwo_bits_divider_if.slave   div_if
);

    typedef enum logic [1:0] {StIdle, StCalc, StFlag} state_e;

    state_e      state_q;
    logic [31:0] rem_q;
    logic [31:0] shift_q;
    logic [31:0] b_q;
    logic [4:0]  cnt_q;
    logic [31:0] q_q;
    logic [31:0] r_q;
    logic        busy_q;
    logic        done_q;
    logic        div_zero_q;
    logic        overflow_q;

    logic [32:0] trial;
    logic        take;
    logic [31:0] rem_next;
    logic [31:0] quo_next;

    // The trial value is 33 bits wide so the bit shifted out of the remainder takes part in
    // the compare. When take is set the difference is below b and fits in 32 bits.
    always_comb begin
        trial    = {rem_q, shift_q[31]};
        take     = (trial >= {1'b0, b_q});
        rem_next = trial[31:0];
        if (take) begin
            rem_next = trial[31:0] - b_q;
        end
        quo_next = {shift_q[30:0], take};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            rem_q      <= '0;
            shift_q    <= '0;
            b_q        <= '0;
            cnt_q      <= '0;
            q_q        <= '0;
            r_q        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (div_if.start) begin
                        b_q        <= div_if.b;
                        rem_q      <= div_if.a[63:32];
                        shift_q    <= div_if.a[31:0];
                        cnt_q      <= '0;
                        busy_q     <= 1'b1;
                        div_zero_q <= 1'b0;
                        overflow_q <= 1'b0;
                        if (div_if.b == 32'd0) begin
                            div_zero_q <= 1'b1;
                            state_q    <= StFlag;
                        end else if (div_if.a[63:32] >= div_if.b) begin
                            overflow_q <= 1'b1;
                            state_q    <= StFlag;
                        end else begin
                            state_q    <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    rem_q   <= rem_next;
                    shift_q <= quo_next;
                    cnt_q   <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        q_q     <= quo_next;
                        r_q     <= rem_next;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                StFlag: begin
                    // shift_q still holds the low dividend word captured at start.
                    q_q     <= 32'hFFFF_FFFF;
                    r_q     <= div_zero_q ? shift_q : 32'd0;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign div_if.q        = q_q;
    assign div_if.r        = r_q;
    assign div_if.busy     = busy_q;
    assign div_if.done     = done_q;
    assign div_if.div_zero = div_zero_q;
    assign div_if.overflow = overflow_q;

endmodule

// File: tb/tb_thirtytwo_bits_divider.sv
// Directed table-driven bench for the 64/32 divider plus handshake and reset corner sequences.
module tb_thirtytwo_bits_divider;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    thirtytwo_bits_divider_if dif ();

    thirtytwo_bits_divider dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .div_if (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        logic        ov;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_start(input logic [63:0] a, input logic [31:0] b);
        @(negedge clk);
        dif.a     = a;
        dif.b     = b;
        dif.start = 1'b1;
        @(posedge clk);
        #1;
        dif.start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (dif.done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic check_result(input string tag, input vec_t v, input int lat);
        check({tag, " latency"}, 64'(lat), 64'(v.lat));
        check({tag, " q"}, 64'(dif.q), 64'(v.q));
        check({tag, " r"}, 64'(dif.r), 64'(v.r));
        check({tag, " div_zero"}, 64'(dif.div_zero), 64'(v.dz));
        check({tag, " overflow"}, 64'(dif.overflow), 64'(v.ov));
    endtask

    initial begin
        int   lat;
        vec_t v;
        checks   = 0;
        failures = 0;

        //           a                         b             q             r             dz    ov    lat
        vecs[0]  = '{64'd100,                  32'd7,        32'd14,       32'd2,        1'b0, 1'b0, 32};
        vecs[1]  = '{64'hFFFF_FFFE_0000_0001,  32'hFFFF_FFFF,32'hFFFF_FFFF,32'd0,        1'b0, 1'b0, 32};
        vecs[2]  = '{64'h0000_0000_1234_5678,  32'd0,        32'hFFFF_FFFF,32'h1234_5678,1'b1, 1'b0, 1};
        vecs[3]  = '{64'h0000_0001_0000_0000,  32'd1,        32'hFFFF_FFFF,32'd0,        1'b0, 1'b1, 1};
        vecs[4]  = '{64'd50,                   32'd5,        32'd10,       32'd0,        1'b0, 1'b0, 32};
        vecs[5]  = '{64'd0,                    32'd3,        32'd0,        32'd0,        1'b0, 1'b0, 32};
        vecs[6]  = '{64'h0000_0000_FFFF_FFFF,  32'd1,        32'hFFFF_FFFF,32'd0,        1'b0, 1'b0, 32};
        vecs[7]  = '{64'd999,                  32'd1000,     32'd0,        32'd999,      1'b0, 1'b0, 32};
        vecs[8]  = '{64'h0000_0005_0000_0000,  32'd5,        32'hFFFF_FFFF,32'd0,        1'b0, 1'b1, 1};
        vecs[9]  = '{64'h0000_0004_FFFF_FFFF,  32'd5,        32'hFFFF_FFFF,32'd4,        1'b0, 1'b0, 32};
        vecs[10] = '{64'd0,                    32'd0,        32'hFFFF_FFFF,32'd0,        1'b1, 1'b0, 1};
        vecs[11] = '{64'hDEAD_BEEF_CAFE_BABE,  32'd0,        32'hFFFF_FFFF,32'hCAFE_BABE,1'b1, 1'b0, 1};
        vecs[12] = '{64'h0000_0001_0000_0000,  32'd2,        32'h8000_0000,32'd0,        1'b0, 1'b0, 32};
        vecs[13] = '{64'h0000_0001_0000_0003,  32'd2,        32'h8000_0001,32'd1,        1'b0, 1'b0, 32};

        rst_n     = 1'b0;
        dif.start = 1'b0;
        dif.a     = '0;
        dif.b     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset q", 64'(dif.q), 64'd0);
        check("reset r", 64'(dif.r), 64'd0);
        check("reset busy", 64'(dif.busy), 64'd0);
        check("reset done", 64'(dif.done), 64'd0);
        check("reset div_zero", 64'(dif.div_zero), 64'd0);
        check("reset overflow", 64'(dif.overflow), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            do_start(vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d busy", i), 64'(dif.busy), 64'd1);
            wait_done(lat);
            check_result($sformatf("vec%0d", i), vecs[i], lat);
        end

        // Start pulsed mid-division with different operands must be ignored.
        do_start(64'd100, 32'd7);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            if (i == 10) begin
                @(negedge clk);
                dif.a     = 64'd77;
                dif.b     = 32'd3;
                dif.start = 1'b1;
            end
            @(posedge clk);
            #1;
            dif.start = 1'b0;
            if (dif.done) begin
                lat = i;
                break;
            end
        end
        v = '{64'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 32};
        check_result("ignored start", v, lat);

        // Back-to-back: start raised in the done cycle.
        dif.a     = 64'd50;
        dif.b     = 32'd5;
        dif.start = 1'b1;
        @(posedge clk);
        #1;
        dif.start = 1'b0;
        check("b2b busy", 64'(dif.busy), 64'd1);
        wait_done(lat);
        v = '{64'd50, 32'd5, 32'd10, 32'd0, 1'b0, 1'b0, 32};
        check_result("b2b", v, lat);
        @(posedge clk);
        #1;
        check("done pulse width", 64'(dif.done), 64'd0);
        check("q hold", 64'(dif.q), 64'd10);

        // Reset asserted at iteration 15 discards the result.
        do_start(64'd100, 32'd7);
        repeat (15) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset q", 64'(dif.q), 64'd0);
        check("midreset r", 64'(dif.r), 64'd0);
        check("midreset busy", 64'(dif.busy), 64'd0);
        check("midreset done", 64'(dif.done), 64'd0);
        check("midreset flags", 64'({dif.div_zero, dif.overflow}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_done(lat);
        check("midreset no done", 64'(lat), -64'sd1);
        do_start(64'd100, 32'd7);
        wait_done(lat);
        v = '{64'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 32};
        check_result("post reset", v, lat);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
